// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit common-anode FND scan controller.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } fnd_state_e;

  typedef logic [1:0] digit_idx_t;

  localparam logic [7:0] FND_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'b1111;

  // Active-low one-hot digit select for a given digit index.
  function automatic logic [3:0] com_sel(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Bus between the value-producing logic and the FND scan controller.
interface fnd_scan_ctrl_if;
  import fnd_pkg::*;

  // load is a one-cycle strobe with no ready: the controller accepts it in every
  // cycle, either into the display register or into the pending register.
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  com;
  logic [7:0]  seg_7;
  logic        pending;
  logic        frame_tick;
  fnd_state_e  state_dbg;

  modport master (
    output en, value, dp_in, load,
    input  com, seg_7, pending, frame_tick, state_dbg
  );

  modport slave (
    input  en, value, dp_in, load,
    output com, seg_7, pending, frame_tick, state_dbg
  );

endinterface

// File: rtl/fnd_scan_ctrl_decoder_7seg.sv
// Hex nibble to active-low 7-segment font {a,b,c,d,e,f,g,dp}; dp is always off here.
module decoder_7seg (
  input  logic [3:0] nibble,
  output logic [7:0] font
);

  always_comb begin
    font = 8'hFF;
    unique case (nibble)
      4'h0: font = 8'h03;
      4'h1: font = 8'h9F;
      4'h2: font = 8'h25;
      4'h3: font = 8'h0D;
      4'h4: font = 8'h99;
      4'h5: font = 8'h49;
      4'h6: font = 8'h41;
      4'h7: font = 8'h1F;
      4'h8: font = 8'h01;
      4'h9: font = 8'h09;
      4'hA: font = 8'h11;
      4'hB: font = 8'hC1;
      4'hC: font = 8'h63;
      4'hD: font = 8'h85;
      4'hE: font = 8'h61;
      4'hF: font = 8'h71;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed 4-digit FND scan controller with tear-free deferred loads.
// Optional FND_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,  // >= 4
  parameter int BLANK_CYC = 16        // 1 <= BLANK_CYC < SCAN_DIV
) (
  input  logic          clk,
  input  logic          reset_n,
  fnd_scan_ctrl_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  typedef logic [PW-1:0] presc_t;
  localparam presc_t SLOT_LAST  = presc_t'(SCAN_DIV - 1);
  localparam presc_t BLANK_LAST = presc_t'(BLANK_CYC - 1);

  fnd_state_e  state_q, state_d;
  presc_t      presc_q, presc_d;
  digit_idx_t  idx_q, idx_d;
  logic [15:0] disp_val_q, disp_val_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pending_q, pending_d;
  logic        frame_tick_q, frame_tick_d;
  logic [3:0]  com_q, com_d;
  logic [7:0]  seg_q, seg_d;

  logic        boundary;
  logic [3:0]  nibble;
  logic [7:0]  font;
  logic        lead_zero;

  assign nibble = 4'(disp_val_q >> {idx_q, 2'b00});

  decoder_7seg u_decoder (
    .nibble (nibble),
    .font   (font)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  assign lead_zero = (idx_q != digit_idx_t'(0)) &&
                     ((disp_val_q >> {idx_q, 2'b00}) == 16'h0000);
`else
  assign lead_zero = 1'b0;
`endif

  // Scan sequencing: IDLE -> BLANK -> ON -> BLANK (next digit) ...
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      presc_d = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          presc_d = '0;
          idx_d   = '0;
        end
        BLANK: begin
          presc_d = presc_q + 1'b1;
          if (presc_q == BLANK_LAST) state_d = ON;
        end
        ON: begin
          if (presc_q == SLOT_LAST) begin
            state_d  = BLANK;
            presc_d  = '0;
            idx_d    = idx_q + digit_idx_t'(1);
            boundary = (idx_q == digit_idx_t'(3));
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Load path: a pending value only reaches the display at a frame boundary.
  always_comb begin
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;
    if (boundary && pending_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pending_d  = 1'b0;
    end
    if (bus.load) begin
      if (state_q == IDLE || boundary) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
        pending_d  = 1'b0;
      end else begin
        pend_val_d = bus.value;
        pend_dp_d  = bus.dp_in;
        pending_d  = 1'b1;
      end
    end
  end

  // frame_tick is high during the last cycle of digit3's slot.
  always_comb begin
    frame_tick_d = (state_d == ON) && (presc_d == SLOT_LAST) &&
                   (idx_d == digit_idx_t'(3));
    com_d = COM_OFF;
    seg_d = FND_OFF;
    if (bus.en && state_q == ON) begin
      com_d = com_sel(idx_q);
      seg_d = (lead_zero ? FND_OFF : font) & {7'h7F, ~disp_dp_q[idx_q]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      com_q        <= COM_OFF;
      seg_q        <= FND_OFF;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      com_q        <= com_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.com        = com_q;
  assign bus.seg_7      = seg_q;
  assign bus.pending    = pending_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
module tb_fnd_scan_ctrl;
  import fnd_pkg::*;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fnd_scan_ctrl_if bus ();

  fnd_scan_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int mon_cyc  = 0;
  logic mon_on = 1'b0;
  logic [13:0] exp_q[$];  // {com, seg_7, frame_tick, pending} per cycle

  // Hand-derived fonts, active-low {a..g,dp}, dp off.
  logic [7:0] font_t [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  logic [15:0] disp_v   = 16'h0;
  logic [3:0]  disp_dp  = 4'h0;
  logic        exp_pend = 1'b0;
  logic [15:0] pend_v   = 16'h0;
  logic [3:0]  pend_dp  = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [13:0] act;
    logic [13:0] e;
    if (mon_on) begin
      act = {bus.com, bus.seg_7, bus.frame_tick, bus.pending};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scan_underflow cyc=%0d actual=%h required=none", mon_cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL scan cyc=%0d com=%b req=%b seg=%b req=%b tick=%b req=%b pend=%b req=%b",
                   mon_cyc, act[13:10], e[13:10], act[9:2], e[9:2], act[1], e[1], act[0], e[0]);
        end
      end
      mon_cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] c, input logic [7:0] s, input logic ft, input logic pd);
    exp_q.push_back({c, s, ft, pd});
    @(posedge clk);
    #1;
  endtask

  task automatic step_off();
    step(COM_OFF, FND_OFF, 1'b0, exp_pend);
  endtask

  // Expected output for cycles 0..last_j of a frame starting at digit0's BLANK.
  task automatic run_frame(input int load_at, input logic [15:0] lv, input logic [3:0] ldp,
                           input int last_j, input bit drop_en);
    logic [15:0] fv;
    logic [3:0]  fdp;
    logic [6:0]  f7;
    logic [7:0]  fe;
    logic [3:0]  c;
    logic [7:0]  s;
    logic        lit;
    int          d, p;
    fv  = disp_v;
    fdp = disp_dp;
    for (int j = 0; j <= last_j; j++) begin
      d   = j / SCAN_DIV;
      p   = j % SCAN_DIV;
      lit = (p >= BLANK_CYC);
      fe  = font_t[4'(fv >> (4 * d))];
      f7  = fe[7:1];
`ifdef FND_LEADING_ZERO_BLANK_EN
      if (d != 0 && (fv >> (4 * d)) == 16'h0) f7 = 7'h7F;
`endif
      c = lit ? 4'(~(4'b0001 << d)) : COM_OFF;
      s = lit ? {f7, ~fdp[d]} : FND_OFF;
      if (j == load_at) begin
        bus.value = lv;
        bus.dp_in = ldp;
        bus.load  = 1'b1;
      end
      if (j == last_j && drop_en) bus.en = 1'b0;
      step(c, s, (j == FRAME - 2), exp_pend);
      bus.load = 1'b0;
      if (j == load_at && j != FRAME - 2) begin
        exp_pend = 1'b1;
        pend_v   = lv;
        pend_dp  = ldp;
      end
      if (j == FRAME - 2) begin
        if (load_at == FRAME - 2) begin
          disp_v  = lv;
          disp_dp = ldp;
        end else if (exp_pend) begin
          disp_v  = pend_v;
          disp_dp = pend_dp;
        end
        exp_pend = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n    = 1'b0;
    bus.en     = 1'b0;
    bus.value  = 16'h0;
    bus.dp_in  = 4'h0;
    bus.load   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_com", 32'(bus.com), 32'(4'b1111));
    chk("rst_seg", 32'(bus.seg_7), 32'(8'hFF));
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
    chk("rst_state", 32'(bus.state_dbg), 32'(IDLE));

    reset_n = 1'b1;
    mon_on  = 1'b1;

    // Load in IDLE goes straight to display.
    bus.value = 16'h1234;
    bus.dp_in = 4'h0;
    bus.load  = 1'b1;
    step_off();
    bus.load  = 1'b0;
    disp_v    = 16'h1234;
    disp_dp   = 4'h0;
    step_off();
    bus.en = 1'b1;
    step_off();
    step_off();

    run_frame(-1, 16'h0, 4'h0, FRAME - 1, 0);            // 1234
    run_frame(10, 16'hABCD, 4'h0, FRAME - 1, 0);         // deferred load in digit1
    run_frame(FRAME - 2, 16'h0F00, 4'h0, FRAME - 1, 0);  // ABCD; load on boundary
    run_frame(5, 16'h0005, 4'b0100, FRAME - 1, 0);       // 0F00
    run_frame(-1, 16'h0, 4'h0, FRAME - 1, 0);            // 0005, dp on digit2
    run_frame(-1, 16'h0, 4'h0, 4, 1);                    // en drops during ON
    step_off();
    step_off();
    step_off();
    bus.en = 1'b1;
    step_off();
    step_off();
    run_frame(3, 16'h9999, 4'hF, 12, 0);                 // restart; pending set
    mon_on = 1'b0;
    chk("queue_drained_1", 32'(exp_q.size()), 32'd0);

    // Mid-frame asynchronous reset while digit1 is lit and a load is pending.
    chk("pre_rst_com", 32'(bus.com), 32'(4'b1101));
`ifdef FND_LEADING_ZERO_BLANK_EN
    chk("pre_rst_seg", 32'(bus.seg_7), 32'(8'hFF));
`else
    chk("pre_rst_seg", 32'(bus.seg_7), 32'(8'h03));
`endif
    chk("pre_rst_pending", 32'(bus.pending), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_com", 32'(bus.com), 32'(4'b1111));
    chk("async_rst_seg", 32'(bus.seg_7), 32'(8'hFF));
    chk("async_rst_pending", 32'(bus.pending), 32'd0);
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    disp_v   = 16'h0;
    disp_dp  = 4'h0;
    exp_pend = 1'b0;
    mon_on   = 1'b1;
    bus.en   = 1'b1;
    step_off();
    step_off();
    run_frame(-1, 16'h0, 4'h0, FRAME - 1, 0);            // 0000 after reset
    mon_on = 1'b0;
    chk("queue_drained_2", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
